// File: rtl/tick_ctrl_pkg.sv
// Shared types and helpers for the tick counter controller.
// COUNT_DOWN_EN (optional macro) adds the key_dir input and down counting.
package tick_ctrl_pkg;

    localparam int COUNT_W = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // One count step, wrapping between 0 and max_v in either direction
    function automatic logic [COUNT_W-1:0] step_count(
        input logic [COUNT_W-1:0] cur,
        input logic [COUNT_W-1:0] max_v,
        input logic               down
    );
        logic [COUNT_W-1:0] nxt;
        if (down) begin
            nxt = (cur == {COUNT_W{1'b0}}) ? max_v : (cur - COUNT_W'(1'b1));
        end else begin
            nxt = (cur >= max_v) ? {COUNT_W{1'b0}} : (cur + COUNT_W'(1'b1));
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tick_counter_ctrl_if.sv
// Key inputs and count outputs of tick_counter_ctrl.
// key_dir exists only when COUNT_DOWN_EN is defined.
interface tick_counter_ctrl_if;
    import tick_ctrl_pkg::*;

    logic               key_start;
    logic               key_clear;
`ifdef COUNT_DOWN_EN
    logic               key_dir;
`endif
    logic [COUNT_W-1:0] counter;
    logic               running;
    logic               tick;

`ifdef COUNT_DOWN_EN
    modport master (output key_start, key_clear, key_dir, input counter, running, tick);
    modport slave  (input key_start, key_clear, key_dir, output counter, running, tick);
`else
    modport master (output key_start, key_clear, input counter, running, tick);
    modport slave  (input key_start, key_clear, output counter, running, tick);
`endif

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer, stable-run debouncer and press pulse for one raw key.
module key_debounce #(
    parameter int DEB_CYC = 1000000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press
);
    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;
    logic             differ_s;
    logic             accept_s;

    // Synchronizer idles at the released level
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_raw;
            sync2_r <= sync1_r;
        end
    end

    // Accept the new level on the DEB_CYC-th consecutive disagreeing sample
    always_comb begin
        differ_s = (sync2_r != level_r);
        accept_s = differ_s && (cnt_r == CNT_LAST);
    end

    // Run length of samples disagreeing with the accepted level
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!differ_s || accept_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end
    end

    // Debounced level plus one-cycle pulse on an accepted 1->0 change
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            level_r <= 1'b1;
            press_r <= 1'b0;
        end else begin
            level_r <= accept_s ? sync2_r : level_r;
            press_r <= accept_s & ~sync2_r;
        end
    end

    assign key_level = level_r;
    assign key_press = press_r;

endmodule

// File: rtl/tick_counter_ctrl.sv
// Start/pause/clear step counter with a CLK_HZ-cycle prescaler.
// Defining COUNT_DOWN_EN adds a debounced key_dir level selecting down counting.
module tick_counter_ctrl
    import tick_ctrl_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int DEB_CYC   = 1000000,
    parameter int MAX_COUNT = 9999
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    tick_counter_ctrl_if.slave  bus
);
    localparam int PRESC_W = $clog2(CLK_HZ);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX  = COUNT_W'(MAX_COUNT);

    state_t             state_r;
    state_t             next_state_s;
    logic [PRESC_W-1:0] presc_r;
    logic [COUNT_W-1:0] counter_r;
    logic               tick_r;
    logic               running_r;
    logic               start_press_s;
    logic               clear_press_s;
    logic               start_level_unused_s;
    logic               clear_level_unused_s;
    logic               dir_down_s;
    logic               zero_s;
    logic               presc_adv_s;
    logic               step_s;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_start (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_raw   (bus.key_start),
        .key_level (start_level_unused_s),
        .key_press (start_press_s)
    );

    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_clear (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_raw   (bus.key_clear),
        .key_level (clear_level_unused_s),
        .key_press (clear_press_s)
    );

`ifdef COUNT_DOWN_EN
    logic dir_level_s;
    logic dir_press_unused_s;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_dir (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_raw   (bus.key_dir),
        .key_level (dir_level_s),
        .key_press (dir_press_unused_s)
    );
    assign dir_down_s = dir_level_s;
`else
    assign dir_down_s = 1'b0;
`endif

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state: clear overrides everything, start toggles run/pause
    always_comb begin
        next_state_s = state_r;
        if (clear_press_s) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    next_state_s = start_press_s ? RUN : IDLE;
                RUN:     next_state_s = start_press_s ? PAUSE : RUN;
                PAUSE:   next_state_s = start_press_s ? RUN : PAUSE;
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Datapath controls; a clear in the step cycle suppresses the step
    always_comb begin
        zero_s      = 1'b0;
        presc_adv_s = 1'b0;
        step_s      = 1'b0;
        if (clear_press_s) begin
            zero_s = 1'b1;
        end else begin
            case (state_r)
                IDLE: zero_s = 1'b1;
                RUN: begin
                    presc_adv_s = 1'b1;
                    step_s      = (presc_r == PRESC_LAST);
                end
                PAUSE:   presc_adv_s = 1'b0;
                default: zero_s = 1'b1;
            endcase
        end
    end

    // Prescaler, count and registered status outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc_r   <= {PRESC_W{1'b0}};
            counter_r <= {COUNT_W{1'b0}};
            tick_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            if (zero_s) begin
                presc_r   <= {PRESC_W{1'b0}};
                counter_r <= {COUNT_W{1'b0}};
            end else if (presc_adv_s) begin
                presc_r   <= step_s ? {PRESC_W{1'b0}} : (presc_r + PRESC_W'(1'b1));
                counter_r <= step_s ? step_count(counter_r, COUNT_MAX, dir_down_s) : counter_r;
            end else begin
                presc_r   <= presc_r;
                counter_r <= counter_r;
            end
            tick_r    <= step_s;
            running_r <= (next_state_s == RUN);
        end
    end

    assign bus.counter = counter_r;
    assign bus.running = running_r;
    assign bus.tick    = tick_r;

endmodule
